// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_pkg                                                                   |
// | Item codes, FSM state encoding, motor indices and timer-width helpers      |
// | shared by the vending motor sequencer.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ITEM_NONE     = 2'b00,
    ITEM_SANDWICH = 2'b01,
    ITEM_WATER    = 2'b10,
    ITEM_RSVD     = 2'b11
  } item_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ITEM_ON  = 3'd1;
  localparam logic [2:0] ST_ITEM_GAP = 3'd2;
  localparam logic [2:0] ST_CHG_ON   = 3'd3;
  localparam logic [2:0] ST_CHG_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int MOTOR_1_IDX = 0;
  localparam int MOTOR_2_IDX = 1;
  localparam int MOTOR_3_IDX = 2;
  localparam int NUM_MOTORS  = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter only ever holds load values (N-1), so clog2 of the largest N suffices.
  function automatic int timer_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_phase_timer                                                           |
// | Loadable down-counter shared by ON, GAP and home-sensor timeout phases.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vend_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - WIDTH'(1);
    end
  end

  assign expired = (r_value == '0);

endmodule : vend_phase_timer
`default_nettype wire

// File: rtl/vend_motor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_motor_sequencer                                                       |
// | Runs one dispense order: item motor pulse, then N change-ejector pulses,   |
// | one motor at a time with fixed on/gap timing.                              |
// | Optional macro VEND_MOTOR_ACK_EN: ON phases end on motor_home, with a      |
// | sticky fault on ACK_TIMEOUT.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vend_motor_sequencer
  import vend_pkg::*;
#(
  parameter int ON_CYCLES   = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_CHANGE  = 15,
  parameter int CHG_W       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_item,
  input  logic [CHG_W-1:0] req_change,
`ifdef VEND_MOTOR_ACK_EN
  input  logic             motor_home,
  output logic             fault,
`endif
  output logic             req_ready,
  output logic             motor_1,
  output logic             motor_2,
  output logic             motor_3,
  output logic             busy,
  output logic             done
);

  localparam int TW = timer_width(ON_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam logic [TW-1:0]    GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [CHG_W-1:0] CHG_MAX  = CHG_W'(MAX_CHANGE);
`ifdef VEND_MOTOR_ACK_EN
  localparam logic [TW-1:0]    ON_LOAD  = TW'(ACK_TIMEOUT - 1);
`else
  localparam logic [TW-1:0]    ON_LOAD  = TW'(ON_CYCLES - 1);
`endif

  logic [2:0]            r_state;
  item_e                 r_item;
  logic [CHG_W-1:0]      r_chg_left;
  logic [NUM_MOTORS-1:0] r_motor;
  logic                  r_busy;
  logic                  r_done;

  logic [2:0]            w_state_nxt;
  item_e                 w_item_nxt;
  logic [CHG_W-1:0]      w_chg_nxt;
  logic [NUM_MOTORS-1:0] w_motor_nxt;
  logic                  w_load;
  logic [TW-1:0]         w_load_val;
  logic                  w_tmr_expired;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_on_end;
  item_e                 w_req_item_n;
  logic [CHG_W-1:0]      w_req_chg;

`ifdef VEND_MOTOR_ACK_EN
  logic r_fault;
  logic w_timeout;
  logic w_fault_set;

  // The ON state always lasts at least one cycle, so sampling home here is "after >=1 cycle on".
  assign w_on_end  = motor_home;
  assign w_timeout = !motor_home && w_tmr_expired;
  assign w_ready   = (r_state == ST_IDLE) && !r_fault;
  assign fault     = r_fault;
`else
  assign w_on_end  = w_tmr_expired;
  assign w_ready   = (r_state == ST_IDLE);
`endif

  assign w_accept     = req_valid && w_ready;
  assign w_req_item_n = ((req_item == ITEM_SANDWICH) || (req_item == ITEM_WATER)) ?
                        item_e'(req_item) : ITEM_NONE;
  assign w_req_chg    = (req_change > CHG_MAX) ? CHG_MAX : req_change;

  vend_phase_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .clk      (clock),
    .rst      (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_tmr_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_item_nxt  = r_item;
    w_chg_nxt   = r_chg_left;
    w_load      = 1'b0;
    w_load_val  = '0;
`ifdef VEND_MOTOR_ACK_EN
    w_fault_set = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_item_nxt = w_req_item_n;
          w_chg_nxt  = w_req_chg;
          if (w_req_item_n != ITEM_NONE) begin
            w_state_nxt = ST_ITEM_ON;
            w_load      = 1'b1;
            w_load_val  = ON_LOAD;
          end else if (w_req_chg != '0) begin
            w_state_nxt = ST_CHG_ON;
            w_load      = 1'b1;
            w_load_val  = ON_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_ITEM_ON, ST_CHG_ON: begin
`ifdef VEND_MOTOR_ACK_EN
        if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_chg_nxt   = '0;
          w_fault_set = 1'b1;
        end else
`endif
        if (w_on_end) begin
          w_state_nxt = (r_state == ST_ITEM_ON) ? ST_ITEM_GAP : ST_CHG_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
          if (r_state == ST_CHG_ON) begin
            w_chg_nxt = r_chg_left - CHG_W'(1);
          end
        end
      end
      ST_ITEM_GAP, ST_CHG_GAP: begin
        if (w_tmr_expired) begin
          if (r_chg_left != '0) begin
            w_state_nxt = ST_CHG_ON;
            w_load      = 1'b1;
            w_load_val  = ON_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Motors are registered from the next state so the first pulse appears one cycle after accept.
  always_comb begin
    w_motor_nxt = '0;
    if (w_state_nxt == ST_ITEM_ON) begin
      if (w_item_nxt == ITEM_SANDWICH) begin
        w_motor_nxt[MOTOR_1_IDX] = 1'b1;
      end else begin
        w_motor_nxt[MOTOR_2_IDX] = 1'b1;
      end
    end else if (w_state_nxt == ST_CHG_ON) begin
      w_motor_nxt[MOTOR_3_IDX] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_item     <= ITEM_NONE;
      r_chg_left <= '0;
      r_motor    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_item     <= w_item_nxt;
      r_chg_left <= w_chg_nxt;
      r_motor    <= w_motor_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef VEND_MOTOR_ACK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end
`endif

  assign req_ready = w_ready;
  assign motor_1   = r_motor[MOTOR_1_IDX];
  assign motor_2   = r_motor[MOTOR_2_IDX];
  assign motor_3   = r_motor[MOTOR_3_IDX];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : vend_motor_sequencer
`default_nettype wire

// File: tb/tb_vend_motor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vend_motor_sequencer                                                    |
// | Scoreboard bench: per-cycle expected trace queued on accept, monitor pops. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vend_motor_sequencer;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int MAXC = 15;
  localparam int CW   = 5;
  localparam int ACK  = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [1:0]    req_item;
  logic [CW-1:0] req_change;
  logic          req_ready, motor_1, motor_2, motor_3, busy, done;
`ifdef VEND_MOTOR_ACK_EN
  logic          motor_home;
  logic          fault;
`endif

  vend_motor_sequencer #(
    .ON_CYCLES   (ON),
    .GAP_CYCLES  (GAP),
    .MAX_CHANGE  (MAXC),
    .CHG_W       (CW),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_item   (req_item),
    .req_change (req_change),
`ifdef VEND_MOTOR_ACK_EN
    .motor_home (motor_home),
    .fault      (fault),
`endif
    .req_ready  (req_ready),
    .motor_1    (motor_1),
    .motor_2    (motor_2),
    .motor_3    (motor_3),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] mot;
    logic       bsy;
    logic       dn;
    logic       rdy;
    logic       flt;
  } rec_t;

  rec_t q[$];
  int   exp_busy_q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  bit   fault_model = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: expected per-cycle trace of one order, from the accept cycle on.
  task automatic push_order(input logic [1:0] it, input logic [CW-1:0] ch);
    int         n;
    bit         has_item;
    logic [2:0] im;
    n        = (int'(ch) > MAXC) ? MAXC : int'(ch);
    has_item = (it == 2'b01) || (it == 2'b10);
    im       = (it == 2'b01) ? 3'b001 : 3'b010;
    q.push_back('{mot: 3'b000, bsy: 1'b0, dn: 1'b0, rdy: 1'b1, flt: fault_model});
`ifdef VEND_MOTOR_ACK_EN
    if (has_item || n > 0) begin
      for (int c = 0; c < ACK; c++)
        q.push_back('{mot: has_item ? im : 3'b100, bsy: 1'b1, dn: 1'b0, rdy: 1'b0, flt: 1'b0});
      q.push_back('{mot: 3'b000, bsy: 1'b1, dn: 1'b1, rdy: 1'b0, flt: 1'b1});
      exp_busy_q.push_back(ACK + 1);
      fault_model = 1'b1;
      return;
    end
`endif
    if (has_item) begin
      for (int c = 0; c < ON; c++)  q.push_back('{mot: im, bsy: 1'b1, dn: 1'b0, rdy: 1'b0, flt: 1'b0});
      for (int c = 0; c < GAP; c++) q.push_back('{mot: 3'b000, bsy: 1'b1, dn: 1'b0, rdy: 1'b0, flt: 1'b0});
    end
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < ON; c++)  q.push_back('{mot: 3'b100, bsy: 1'b1, dn: 1'b0, rdy: 1'b0, flt: 1'b0});
      for (int c = 0; c < GAP; c++) q.push_back('{mot: 3'b000, bsy: 1'b1, dn: 1'b0, rdy: 1'b0, flt: 1'b0});
    end
    q.push_back('{mot: 3'b000, bsy: 1'b1, dn: 1'b1, rdy: 1'b0, flt: 1'b0});
    exp_busy_q.push_back((has_item ? ON + GAP : 0) + n * (ON + GAP) + 1);
  endtask

  always @(negedge clock) begin
    rec_t e;
    if (mon_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{mot: 3'b000, bsy: 1'b0, dn: 1'b0, rdy: !fault_model, flt: fault_model};
      check("motors", {29'd0, motor_3, motor_2, motor_1}, {29'd0, e.mot});
      check("busy", {31'd0, busy}, {31'd0, e.bsy});
      check("done", {31'd0, done}, {31'd0, e.dn});
      check("req_ready", {31'd0, req_ready}, {31'd0, e.rdy});
`ifdef VEND_MOTOR_ACK_EN
      check("fault", {31'd0, fault}, {31'd0, e.flt});
`endif
      tests++;
      assert ($onehot0({motor_3, motor_2, motor_1})) else begin
        fails++;
        $display("FAIL one_motor @%0t: got %b expected at most one high", $time, {motor_3, motor_2, motor_1});
      end
      if (busy === 1'b1) busy_cnt++;
      else busy_cnt = 0;
      if (done === 1'b1) begin
        if (exp_busy_q.size() == 0) check("busy_cycles_unexpected_done", 32'd1, 32'd0);
        else check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
      end
    end
  end

  // Called at posedge+1: the model is idle in this cycle exactly when the trace queue is empty.
  task automatic cyc(input bit v, input logic [1:0] it, input logic [CW-1:0] ch);
    req_valid  = v;
    req_item   = it;
    req_change = ch;
    if (v && q.size() == 0 && !fault_model) push_order(it, ch);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      cyc(1'b0, 2'b00, '0);
      n++;
    end
    if (q.size() != 0) begin
      check("order_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic reset_mid();
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    q.delete();
    exp_busy_q.delete();
    fault_model = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_item   = 2'b00;
    req_change = '0;
`ifdef VEND_MOTOR_ACK_EN
    motor_home = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_motors", {29'd0, motor_3, motor_2, motor_1}, 32'd0);
`ifdef VEND_MOTOR_ACK_EN
    check("rst_fault", {31'd0, fault}, 32'd0);
`endif
    reset  = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

`ifdef VEND_MOTOR_ACK_EN
    cyc(1'b1, 2'b00, 5'd0);
    wait_idle(50);
    cyc(1'b1, 2'b01, 5'd3);
    wait_idle(100);
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'b10, 5'd1);
    reset_mid();
    cyc(1'b0, 2'b00, 5'd0);
    cyc(1'b1, 2'b00, 5'd0);
    wait_idle(50);
`else
    cyc(1'b1, 2'b01, 5'd1);
    wait_idle(100);
    cyc(1'b1, 2'b10, 5'd0);
    wait_idle(100);
    cyc(1'b1, 2'b00, 5'd20);
    wait_idle(200);
    cyc(1'b1, 2'b00, 5'd0);
    wait_idle(20);
    cyc(1'b1, 2'b11, 5'd2);
    wait_idle(100);
    // Valid held high with changing data across orders.
    for (int i = 0; i < 40; i++) cyc(1'b1, 2'($urandom), 5'($urandom_range(0, 3)));
    wait_idle(200);
    // Reset in the third motor_1 cycle.
    cyc(1'b1, 2'b01, 5'd2);
    cyc(1'b0, 2'b00, 5'd0);
    cyc(1'b0, 2'b00, 5'd0);
    reset_mid();
    cyc(1'b0, 2'b00, 5'd0);
    cyc(1'b0, 2'b00, 5'd0);
    for (int k = 0; k < 30; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(1'b0, 2'($urandom), 5'($urandom));
      cyc(1'b1, 2'($urandom), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) begin
        int d;
        d = $urandom_range(0, 20);
        for (int g = 0; g < d; g++) cyc(1'b0, 2'b00, 5'd0);
        reset_mid();
        cyc(1'b0, 2'b00, 5'd0);
      end else begin
        wait_idle(200);
      end
    end
`endif
    cyc(1'b0, 2'b00, 5'd0);
    cyc(1'b0, 2'b00, 5'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vend_motor_sequencer
`default_nettype wire
